// File: rtl/stress_pkg.sv
// Shared mode/state types and the duty clamp for the stress pattern generator.
package stress_pkg;

  typedef enum logic [1:0] {
    ST_LOW    = 2'd0,
    ST_HIGH   = 2'd1,
    ST_CONT   = 2'd2,
    ST_SPREAD = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2
  } state_e;

  function automatic int unsigned clamp_duty(input int unsigned duty, input int unsigned period);
    return (duty > period) ? period : duty;
  endfunction

endpackage

// File: rtl/stress_chan.sv
// One stress channel: shadow/active config, spread accumulator, registered output bit
// and saturating stressed-cycle counter. Output updates one cycle after the phase it reflects.
module stress_chan
  import stress_pkg::*;
#(
  parameter int CNT_W = 6,
  parameter int ACC_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             i_we,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W:0]   i_duty,
  input  logic [CNT_W-1:0] i_ph,
  input  logic             i_load,
  input  logic             i_adv,
  input  logic             i_zero,
  input  logic             i_clr,
  output logic             o_stress,
  output logic [ACC_W-1:0] o_cnt
);

  localparam int unsigned P = 2**CNT_W;

  mode_e            r_sh_mode;
  mode_e            r_act_mode;
  logic [CNT_W:0]   r_sh_duty;
  logic [CNT_W:0]   r_act_duty;
  logic [CNT_W-1:0] r_acc;
  logic             r_out;
  logic [ACC_W-1:0] r_cnt;
  logic [CNT_W:0]   w_duty_c;
  logic [CNT_W:0]   w_sum;
  logic             w_bit;

  assign w_duty_c = (CNT_W+1)'(clamp_duty(32'(i_duty), P));
  assign w_sum    = {1'b0, r_acc} + r_act_duty;

  always_comb begin
    w_bit = 1'b0;
    case (r_act_mode)
      ST_LOW:    w_bit = 1'b0;
      ST_HIGH:   w_bit = 1'b1;
      ST_CONT:   w_bit = ({1'b0, i_ph} < r_act_duty);
      ST_SPREAD: w_bit = w_sum[CNT_W];
      default:   w_bit = 1'b0;
    endcase
  end

  // i_load covers both the start load and the period-boundary reload; the
  // shadow read here is the pre-write value, so a same-cycle write waits a period.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_sh_mode  <= ST_LOW;
      r_sh_duty  <= '0;
      r_act_mode <= ST_LOW;
      r_act_duty <= '0;
      r_acc      <= '0;
      r_out      <= 1'b0;
    end else begin
      if (i_we) begin
        r_sh_mode <= mode_e'(i_mode);
        r_sh_duty <= w_duty_c;
      end
      if (i_load) begin
        r_act_mode <= r_sh_mode;
        r_act_duty <= r_sh_duty;
      end
      if (i_load)
        r_acc <= '0;
      else if (i_adv && (r_act_mode == ST_SPREAD))
        r_acc <= w_sum[CNT_W-1:0];
      if (i_zero)
        r_out <= 1'b0;
      else if (i_adv)
        r_out <= w_bit;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_cnt <= '0;
    else if (i_clr)
      r_cnt <= '0;
    else if (r_out && !(&r_cnt))
      r_cnt <= r_cnt + ACC_W'(1);
  end

  assign o_stress = r_out;
  assign o_cnt    = r_cnt;

endmodule

// File: rtl/stress_pattern_gen.sv
// Multi-channel stress waveform generator: shared phase counter and run/pause/stop FSM.
// Start-to-pattern latency 2 cycles; config reloads only on period boundaries.
module stress_pattern_gen
  import stress_pkg::*;
#(
  parameter int NCH   = 8,
  parameter int CNT_W = 6,
  parameter int ACC_W = 32,
  localparam int CH_W = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             cfg_we,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [1:0]       cfg_mode,
  input  logic [CNT_W:0]   cfg_duty,
  input  logic             clr_cnt,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [ACC_W-1:0] rd_cnt,
  output logic [NCH-1:0]   stress_o,
  output logic             period_end,
  output logic             busy
);

  state_e           r_state;
  state_e           w_next;
  logic [CNT_W-1:0] r_ph;
  logic             r_pend;
  logic             w_load;
  logic             w_adv;
  logic             w_zero;
  logic             w_wrap;
  logic [NCH-1:0]   w_we;
  logic [ACC_W-1:0] w_cnt [NCH];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start && !stop) w_next = S_RUN;
      S_RUN:   if (stop) w_next = S_IDLE; else if (pause) w_next = S_PAUSE;
      S_PAUSE: if (stop) w_next = S_IDLE; else if (!pause) w_next = S_RUN;
      default: w_next = S_IDLE;
    endcase
  end

  // Phase advances on every cycle that ends in RUN, so a pause freezes
  // exactly the cycles during which the pause level is high.
  always_comb begin
    busy   = (r_state != S_IDLE);
    w_load = (r_state == S_IDLE) && (w_next == S_RUN);
    w_adv  = (r_state != S_IDLE) && (w_next == S_RUN);
    w_zero = (w_next == S_IDLE);
    w_wrap = w_adv && (&r_ph);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_ph   <= '0;
      r_pend <= 1'b0;
    end else begin
      if (w_zero || w_load)
        r_ph <= '0;
      else if (w_adv)
        r_ph <= r_ph + CNT_W'(1);
      r_pend <= w_wrap;
    end
  end

  assign period_end = r_pend;

  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    assign w_we[gi] = cfg_we && (cfg_ch == CH_W'(gi));

    stress_chan #(
      .CNT_W (CNT_W),
      .ACC_W (ACC_W)
    ) u_chan (
      .clk      (clk),
      .rstn     (rstn),
      .i_we     (w_we[gi]),
      .i_mode   (cfg_mode),
      .i_duty   (cfg_duty),
      .i_ph     (r_ph),
      .i_load   (w_load || w_wrap),
      .i_adv    (w_adv),
      .i_zero   (w_zero),
      .i_clr    (clr_cnt),
      .o_stress (stress_o[gi]),
      .o_cnt    (w_cnt[gi])
    );
  end

  always_comb begin
    rd_cnt = '0;
    for (int i = 0; i < NCH; i++)
      if (rd_ch == CH_W'(i)) rd_cnt = w_cnt[i];
  end

endmodule

// File: tb/tb_stress_pattern_gen.sv
// Directed bench for stress_pattern_gen: per-mode period vectors plus timing corner sequences.
module tb_stress_pattern_gen;

  localparam int NCH   = 6;
  localparam int CNT_W = 6;
  localparam int P     = 64;
  localparam int CH_W  = 3;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             start = 1'b0, stop = 1'b0, pause = 1'b0;
  logic             cfg_we = 1'b0, clr_cnt = 1'b0;
  logic [CH_W-1:0]  cfg_ch = '0, rd_ch = '0;
  logic [1:0]       cfg_mode = '0;
  logic [CNT_W:0]   cfg_duty = '0;
  logic [31:0]      rd_cnt;
  logic [3:0]       rd_cnt4;
  logic [NCH-1:0]   stress_o, stress4;
  logic             period_end, period_end4, busy, busy4;

  int n_run  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stress_pattern_gen #(.NCH(NCH), .CNT_W(CNT_W), .ACC_W(32)) dut (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .clr_cnt(clr_cnt), .rd_ch(rd_ch), .rd_cnt(rd_cnt), .stress_o(stress_o),
    .period_end(period_end), .busy(busy)
  );

  stress_pattern_gen #(.NCH(NCH), .CNT_W(CNT_W), .ACC_W(4)) dut4 (
    .clk(clk), .rstn(rstn), .start(start), .stop(stop), .pause(pause),
    .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode), .cfg_duty(cfg_duty),
    .clr_cnt(clr_cnt), .rd_ch(rd_ch), .rd_cnt(rd_cnt4), .stress_o(stress4),
    .period_end(period_end4), .busy(busy4)
  );

  typedef struct {
    int         mode;
    int         duty;
    int         highs;
    logic [7:0] first8;
    int         maxlow;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_run++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int ch, input int mode, input int duty);
    cfg_we   = 1'b1;
    cfg_ch   = CH_W'(ch);
    cfg_mode = 2'(mode);
    cfg_duty = (CNT_W+1)'(duty);
    cyc();
    cfg_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic do_stop();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
  endtask

  initial begin
    int highs, pe, pe_at, run, maxlow, others, held_bad;
    int cnt[4];
    logic [7:0] first;

    // mode, duty, highs per period, ph0..7 pattern (bit k = ph k), longest low run
    vecs[0] = '{2, 16,  16, 8'hFF, 48};
    vecs[1] = '{3, 16,  16, 8'h88,  3};
    vecs[2] = '{3, 48,  48, 8'hEE,  1};
    vecs[3] = '{2, 64,  64, 8'hFF,  0};
    vecs[4] = '{2, 127, 64, 8'hFF,  0};
    vecs[5] = '{3, 0,    0, 8'h00, 64};
    vecs[6] = '{1, 0,   64, 8'hFF,  0};
    vecs[7] = '{0, 40,   0, 8'h00, 64};
    vecs[8] = '{3, 64,  64, 8'hFF,  0};
    vecs[9] = '{2, 0,    0, 8'h00, 64};

    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    cyc();
    chk("reset stress_o", stress_o, 0);
    chk("reset period_end", period_end, 0);
    chk("reset busy", busy, 0);
    chk("reset rd_cnt", rd_cnt, 0);

    for (int v = 0; v < 10; v++) begin
      clr_cnt = 1'b1;
      wr(0, vecs[v].mode, vecs[v].duty);
      clr_cnt = 1'b0;
      pulse_start();
      chk($sformatf("v%0d busy after start", v), busy, 1);
      chk($sformatf("v%0d out before pattern", v), stress_o[0], 0);
      highs = 0; pe = 0; pe_at = -1; run = 0; maxlow = 0; first = '0;
      for (int k = 0; k < P; k++) begin
        cyc();
        if (stress_o[0]) begin
          highs++;
          run = 0;
        end else begin
          run++;
          if (run > maxlow) maxlow = run;
        end
        if (k < 8) first[k] = stress_o[0];
        if (period_end) begin
          pe++;
          pe_at = k;
        end
      end
      chk($sformatf("v%0d highs", v), highs, vecs[v].highs);
      chk($sformatf("v%0d first8", v), first, vecs[v].first8);
      chk($sformatf("v%0d maxlow", v), maxlow, vecs[v].maxlow);
      chk($sformatf("v%0d period_end count", v), pe, 1);
      chk($sformatf("v%0d period_end pos", v), pe_at, P - 1);
      do_stop();
      rd_ch = '0;
      #1;
      chk($sformatf("v%0d busy after stop", v), busy, 0);
      chk($sformatf("v%0d out after stop", v), stress_o, 0);
      chk($sformatf("v%0d counter", v), rd_cnt, vecs[v].highs);
      chk($sformatf("v%0d counter sat4", v), rd_cnt4, (vecs[v].highs > 15) ? 15 : vecs[v].highs);
    end

    // Mid-period writes: ph30 duty 8, ph31 invalid channel, boundary-cycle write duty 4.
    clr_cnt = 1'b1;
    wr(0, 2, 16);
    clr_cnt = 1'b0;
    pulse_start();
    cnt = '{0, 0, 0, 0};
    others = 0;
    for (int k = 0; k < 4 * P; k++) begin
      cfg_we   = (k == 30) || (k == 95) || (k == 127);
      cfg_ch   = (k == 95) ? CH_W'(6) : CH_W'(0);
      cfg_mode = (k == 95) ? 2'd1 : 2'd2;
      cfg_duty = (k == 127) ? 7'd4 : ((k == 95) ? 7'd64 : 7'd8);
      cyc();
      if (stress_o[0]) cnt[k / P]++;
      if (stress_o[NCH-1:1] != '0) others++;
    end
    cfg_we = 1'b0;
    chk("cfgwr period0 highs", cnt[0], 16);
    chk("cfgwr period1 highs", cnt[1], 8);
    chk("cfgwr period2 highs", cnt[2], 8);
    chk("cfgwr period3 highs", cnt[3], 4);
    chk("cfgwr invalid ch", others, 0);
    do_stop();

    // Pause 10 cycles at ph5 with ch0 high; ch2 static high.
    clr_cnt = 1'b1;
    wr(2, 1, 0);
    clr_cnt = 1'b0;
    wr(0, 2, 16);
    pulse_start();
    highs = 0; pe = 0; pe_at = -1; held_bad = 0;
    for (int k = 0; k < P + 10; k++) begin
      pause = (k >= 5) && (k < 15);
      cyc();
      if (stress_o[0]) highs++;
      if (k >= 5 && k < 15 && (stress_o[0] !== 1'b1 || busy !== 1'b1)) held_bad++;
      if (period_end) begin
        pe++;
        pe_at = k;
      end
    end
    pause = 1'b0;
    chk("pause held high", held_bad, 0);
    chk("pause highs", highs, 26);
    chk("pause period_end count", pe, 1);
    chk("pause period_end pos", pe_at, P + 9);
    rd_ch = CH_W'(0);
    #1;
    chk("pause ch0 counter", rd_cnt, 26);
    rd_ch = CH_W'(2);
    #1;
    chk("ch2 counter", rd_cnt, 73);
    chk("ch2 counter sat4", rd_cnt4, 15);
    clr_cnt = 1'b1;
    cyc();
    clr_cnt = 1'b0;
    chk("clr over inc", rd_cnt, 0);
    chk("clr over inc sat4", rd_cnt4, 0);
    cyc();
    chk("count after clr", rd_cnt, 1);
    stop = 1'b1;
    start = 1'b1;
    cyc();
    chk("stop+start from run busy", busy, 0);
    chk("stop+start from run out", stress_o, 0);
    cyc();
    stop = 1'b0;
    start = 1'b0;
    chk("stop+start from idle busy", busy, 0);

    // Asynchronous reset mid-run.
    pulse_start();
    repeat (20) cyc();
    chk("pre-reset ch2 high", stress_o[2], 1);
    #2 rstn = 1'b0;
    #1;
    chk("async reset out", stress_o, 0);
    chk("async reset busy", busy, 0);
    chk("async reset counter", rd_cnt, 0);
    @(negedge clk);
    rstn = 1'b1;
    cyc();
    pulse_start();
    repeat (5) cyc();
    chk("post-reset config cleared", stress_o, 0);
    chk("post-reset busy", busy, 1);
    do_stop();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
